// File: rtl/divider_pkg.sv
// Shared CPU header: ALU opcodes, datapath width and divider latency constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package divider_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_DIV
    } alu_op_e;

    // Cycles from an accepted start to the done pulse.
    localparam int DIV_CYCLES  = 34;
    localparam int DIV0_CYCLES = 2;

endpackage

// File: rtl/divider_if.sv
// Request/result bundle between the ALU issue logic and the divider.
// Latency: n/a (wires only).
// Backpressure: start is only honoured while busy is low.
interface divider_if #(parameter int DW = 32);

    logic          start;
    logic          signed_op;
    logic [DW-1:0] din_a;
    logic [DW-1:0] din_b;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          vout;

    modport master (
        output start, signed_op, din_a, din_b,
        input  busy, done, quotient, remainder, vout
    );

    modport slave (
        input  start, signed_op, din_a, din_b,
        output busy, done, quotient, remainder, vout
    );

endinterface

// File: rtl/divider.sv
// Iterative radix-2 restoring divider, signed/unsigned, results feed the ALU result mux.
// Latency: done 34 cycles after an accepted start (2 for divide-by-zero).
// Backpressure: start is ignored while busy; results hold until the next operation completes.
module divider
    import divider_pkg::*;
#(
    parameter int DW = XLEN
)
(
    input  logic     clk,
    input  logic     reset,
    divider_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e        state_q, state_d;
    logic [5:0]    cnt_q;
    logic [DW-1:0] rem_q, quo_q, div_q;
    logic          q_neg_q, r_neg_q, div0_q, ovf_q;
    logic [DW-1:0] quotient_q, remainder_q;
    logic          vout_q;

    logic          a_neg, b_neg, b_zero, is_ovf;
    logic [DW-1:0] a_mag, b_mag;
    logic [DW:0]   sh_rem, trial;
    logic          trial_ok;

    // Operand signs and magnitudes; |min_int| stays representable as unsigned.
    always_comb begin
        a_neg  = bus.signed_op & bus.din_a[DW-1];
        b_neg  = bus.signed_op & bus.din_b[DW-1];
        a_mag  = a_neg ? (~bus.din_a + 1'b1) : bus.din_a;
        b_mag  = b_neg ? (~bus.din_b + 1'b1) : bus.din_b;
        b_zero = (bus.din_b == '0);
        is_ovf = bus.signed_op && (bus.din_a == {1'b1, {(DW-1){1'b0}}}) && (bus.din_b == '1);
    end

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
    // A set shifted-out MSB means the partial remainder already exceeds any divisor.
    always_comb begin
        sh_rem   = {rem_q, quo_q[DW-1]};
        trial    = sh_rem - {1'b0, div_q};
        trial_ok = sh_rem[DW] | ~trial[DW];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = b_zero ? FIX : CALC;
            CALC: if (cnt_q == 6'(DW-1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Working datapath and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            div0_q      <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            vout_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    cnt_q   <= '0;
                    div_q   <= b_mag;
                    q_neg_q <= a_neg ^ b_neg;
                    r_neg_q <= a_neg;
                    div0_q  <= b_zero;
                    ovf_q   <= is_ovf;
                    quo_q   <= a_mag;
                    // Divide-by-zero returns the raw dividend as remainder.
                    rem_q   <= b_zero ? bus.din_a : '0;
                end
                CALC: begin
                    cnt_q <= cnt_q + 6'd1;
                    rem_q <= trial_ok ? trial[DW-1:0] : sh_rem[DW-1:0];
                    quo_q <= {quo_q[DW-2:0], trial_ok};
                end
                FIX: begin
                    if (div0_q) begin
                        quotient_q  <= '1;
                        remainder_q <= rem_q;
                    end else begin
                        quotient_q  <= q_neg_q ? (~quo_q + 1'b1) : quo_q;
                        remainder_q <= r_neg_q ? (~rem_q + 1'b1) : rem_q;
                    end
                    vout_q <= div0_q | ovf_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.vout      = vout_q;

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the divider.
// Latency: checks done timing against DIV_CYCLES / DIV0_CYCLES.
// Backpressure: exercises start-while-busy and reset mid-operation.
module tb_divider;
    import divider_pkg::*;

    logic clk;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    divider_if #(.DW(32)) bus ();

    divider #(.DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation, follow it to done, check timing, busy and results.
    // inject > 0 pulses a second start with other operands at that cycle.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input logic exp_v, input int inject);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.signed_op = sgn;
        bus.din_a     = a;
        bus.din_b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat       = 1;
        busy_ok   = 1'b1;
        while (bus.done !== 1'b1 && lat <= 60) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (lat == inject) begin
                bus.start     = 1'b1;
                bus.signed_op = 1'b0;
                bus.din_a     = 32'd9;
                bus.din_b     = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check({tag, " latency"},      32'(lat),       32'(exp_lat));
        check({tag, " busy_run"},     32'(busy_ok),   32'd1);
        check({tag, " busy_at_done"}, 32'(bus.busy),  32'd1);
        check({tag, " quotient"},     bus.quotient,   exp_q);
        check({tag, " remainder"},    bus.remainder,  exp_r);
        check({tag, " vout"},         32'(bus.vout),  32'(exp_v));
        @(negedge clk);
        check({tag, " done_pulse"},   32'(bus.done),  32'd0);
        check({tag, " busy_after"},   32'(bus.busy),  32'd0);
        check({tag, " q_held"},       bus.quotient,   exp_q);
    endtask

    initial begin
        logic saw_done;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.din_a     = '0;
        bus.din_b     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("reset busy",      32'(bus.busy), 32'd0);
        check("reset done",      32'(bus.done), 32'd0);
        check("reset quotient",  bus.quotient,  32'd0);
        check("reset remainder", bus.remainder, 32'd0);
        check("reset vout",      32'(bus.vout), 32'd0);

        run_op("u100/7",   1'b0, 32'd100,       32'd7,         DIV_CYCLES,  32'd14,        32'd2,         1'b0, 0);
        run_op("s-7/2",    1'b1, 32'hFFFFFFF9,  32'd2,         DIV_CYCLES,  32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 0);
        run_op("s7/-2",    1'b1, 32'd7,         32'hFFFFFFFE,  DIV_CYCLES,  32'hFFFFFFFD,  32'd1,         1'b0, 0);
        run_op("s-7/-2",   1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  DIV_CYCLES,  32'd3,         32'hFFFFFFFF,  1'b0, 0);
        run_op("u5/0",     1'b0, 32'd5,         32'd0,         DIV0_CYCLES, 32'hFFFFFFFF,  32'd5,         1'b1, 0);
        run_op("s-5/0",    1'b1, 32'hFFFFFFFB,  32'd0,         DIV0_CYCLES, 32'hFFFFFFFF,  32'hFFFFFFFB,  1'b1, 0);
        run_op("s_ovf",    1'b1, 32'h80000000,  32'hFFFFFFFF,  DIV_CYCLES,  32'h80000000,  32'd0,         1'b1, 0);
        run_op("u_min/-1", 1'b0, 32'h80000000,  32'hFFFFFFFF,  DIV_CYCLES,  32'd0,         32'h80000000,  1'b0, 0);
        run_op("s_min/1",  1'b1, 32'h80000000,  32'd1,         DIV_CYCLES,  32'h80000000,  32'd0,         1'b0, 0);
        run_op("u_max/1",  1'b0, 32'hFFFFFFFF,  32'd1,         DIV_CYCLES,  32'hFFFFFFFF,  32'd0,         1'b0, 0);
        run_op("u_max/m1", 1'b0, 32'hFFFFFFFF,  32'hFFFFFFFE,  DIV_CYCLES,  32'd1,         32'd1,         1'b0, 0);
        run_op("ignored",  1'b0, 32'd100,       32'd7,         DIV_CYCLES,  32'd14,        32'd2,         1'b0, 10);

        // Reset at cycle 10 of an operation in flight.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.din_a     = 32'd100;
        bus.din_b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy",      32'(bus.busy), 32'd0);
        check("abort done",      32'(bus.done), 32'd0);
        check("abort quotient",  bus.quotient,  32'd0);
        check("abort remainder", bus.remainder, 32'd0);
        check("abort vout",      32'(bus.vout), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort no_done", 32'(saw_done), 32'd0);
        run_op("post_reset", 1'b0, 32'd100, 32'd7, DIV_CYCLES, 32'd14, 32'd2, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter: DW, 32, operand/result width; only 32 is supported by the CPU.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request; sampled only in IDLE.
REQ-006 Port: signed_op  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
REQ-007 Port: din_a  input  DW  dividend; sampled with start.
REQ-008 Port: din_b  input  DW  divisor; sampled with start.
REQ-009 Port: busy  output  1  high from the cycle after an accepted start until the cycle done is high, inclusive.
REQ-010 Port: done  output  1  single-cycle pulse; results valid.
REQ-011 Port: quotient  output  DW  quotient, held until the next accepted start.
REQ-012 Port: remainder  output  DW  remainder, held until the next accepted start.
REQ-013 Port: vout  output  1  set on divide-by-zero or signed overflow, held with the results.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, FIX and DONE; reset state is IDLE.
REQ-015 IDLE: start=1 with din_b!=0 SHALL latch the operand magnitudes and signs, clear the 6-bit iteration counter, and go to CALC.
REQ-016 IDLE: start=1 with din_b==0 SHALL go directly to FIX with the div0 flag set.
REQ-017 CALC SHALL perform one radix-2 restoring step per cycle: shift {rem,quo} left 1, trial-subtract the divisor magnitude, keep the difference and set quo[0] when non-negative.
REQ-018 CALC SHALL run exactly DW cycles, then go to FIX.
REQ-019 FIX SHALL negate the quotient when the operand signs differ (signed_op only).
REQ-020 FIX SHALL negate the remainder when the dividend is negative (signed_op only), so the remainder sign follows the dividend.
REQ-021 FIX SHALL register quotient, remainder and vout, then go to DONE.
REQ-022 DONE SHALL assert done for one cycle and return to IDLE.
REQ-023 Latency: start accepted at edge N gives done high in cycle N+34 (normal) or N+2 (divide-by-zero); a new start is accepted in the cycle after done.
REQ-024 start while not in IDLE SHALL be ignored, with no effect on the operation in flight.
REQ-025 Divide-by-zero SHALL give quotient=all ones, remainder=din_a, vout=1 (both signed and unsigned).
REQ-026 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient=0x80000000, remainder=0, vout=1.
REQ-027 All other cases SHALL give vout=0.
REQ-028 Magnitudes SHALL be DW-bit unsigned (|0x80000000| = 0x80000000); the trial subtract SHALL be DW+1 bits wide.

Reset
REQ-029 Reset SHALL force state=IDLE, busy=0, done=0, quotient=0, remainder=0, vout=0, counter=0.
REQ-030 Reset mid-operation SHALL abort with no done pulse; start is accepted in the first cycle after reset is deasserted.

Structure
REQ-031 The DIV opcode and the divider latency constants (DIV_CYCLES=34, DIV0_CYCLES=2) SHALL live in the shared CPU header alongside the ALU opcodes.
REQ-032 FSM state encodings SHALL be local to the module.
REQ-033 No sub-module: the datapath SHALL be a single module whose results are presented to the ALU result mux.

Verification
REQ-034 Unsigned 100/7, start at cycle 0 -> done at cycle 34, quotient=14, remainder=2, vout=0; busy high cycles 1-34.
REQ-035 Signed 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF, vout=0.
REQ-036 Unsigned 5/0 -> done at cycle 2, quotient=0xFFFFFFFF, remainder=5, vout=1; signed -5/0 -> remainder=0xFFFFFFFB.
REQ-037 Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, vout=1; the same operands unsigned -> quotient=0, remainder=0x80000000, vout=0.
REQ-038 start pulsed again at cycle 10 with other operands -> ignored, first result unchanged.
REQ-039 reset at cycle 10 -> no done, outputs 0; a new 100/7 then completes correctly 34 cycles later.
